// File: rtl/reg_file_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_pkg
// Description : Shared widths, zero-register index and register typedefs for
//               the register file, decode and writeback stages.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_sb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // Index of the hardwired zero register.
  localparam int ZERO_IDX = 0;

  typedef logic        [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic signed [DEF_DATA_W-1:0] reg_data_t;

endpackage : reg_file_sb_pkg
`default_nettype wire

// File: rtl/reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb_if
// Description : Read, writeback and reservation signals between the issue /
//               writeback stages (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_sb_if #(
  parameter int DATA_W = reg_file_sb_pkg::DEF_DATA_W,
  parameter int ADDR_W = reg_file_sb_pkg::DEF_ADDR_W
);

  logic        [ADDR_W-1:0] rs;
  logic        [ADDR_W-1:0] rt;
  logic signed [DATA_W-1:0] data_out_one;
  logic signed [DATA_W-1:0] data_out_two;
  logic        [ADDR_W-1:0] rd;
  logic signed [DATA_W-1:0] data_in;
  logic                     write_enable;
  logic                     rsv_valid;
  logic        [ADDR_W-1:0] rsv_addr;
  logic                     rsv_ready;
  logic                     rs_busy;
  logic                     rt_busy;
  logic        [ADDR_W:0]   pending;

  modport master (
    output rs, rt, rd, data_in, write_enable, rsv_valid, rsv_addr,
    input  data_out_one, data_out_two, rsv_ready, rs_busy, rt_busy, pending
  );

  modport slave (
    input  rs, rt, rd, data_in, write_enable, rsv_valid, rsv_addr,
    output data_out_one, data_out_two, rsv_ready, rs_busy, rt_busy, pending
  );

endinterface : reg_file_sb_if
`default_nettype wire

// File: rtl/reg_file_sb_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits for in-flight writes, count of
//               reserved registers and the reservation / source-busy flags.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import reg_file_sb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic [ADDR_W-1:0] rs,
  input  wire logic [ADDR_W-1:0] rt,
  input  wire logic [ADDR_W-1:0] rd,
  input  wire logic              write_enable,
  input  wire logic              eff_we,
  input  wire logic              rsv_valid,
  input  wire logic [ADDR_W-1:0] rsv_addr,
  output logic                   rsv_ready,
  output logic                   rs_busy,
  output logic                   rt_busy,
  output logic      [ADDR_W:0]   pending
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A  = ADDR_W'(ZERO_IDX);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

  logic [DEPTH-1:0] busy_d, busy_q;
  logic [ADDR_W:0]  pending_d, pending_q;
  logic             rsv_is_zero, rs_is_zero, rt_is_zero;
  logic             set_en, clr_en;

  assign rsv_is_zero = (ZERO_REG != 0) && (rsv_addr == ZERO_A);
  assign rs_is_zero  = (ZERO_REG != 0) && (rs == ZERO_A);
  assign rt_is_zero  = (ZERO_REG != 0) && (rt == ZERO_A);

  // A busy destination can still be reserved in the cycle its writeback lands.
  assign rsv_ready = rsv_is_zero || !busy_q[rsv_addr] ||
                     (write_enable && (rd == rsv_addr));

  assign set_en = rsv_valid && rsv_ready && !rsv_is_zero;
  assign clr_en = eff_we && busy_q[rd];

  // A source being written back this cycle is forwarded, so it is not busy.
  assign rs_busy = busy_q[rs] && !rs_is_zero &&
                   !((BYPASS != 0) && eff_we && (rd == rs));
  assign rt_busy = busy_q[rt] && !rt_is_zero &&
                   !((BYPASS != 0) && eff_we && (rd == rt));

  assign pending = pending_q;

  // Next busy vector and count; set is applied after clear so a new
  // reservation on the register being written back survives.
  always_comb begin
    busy_d    = busy_q;
    pending_d = pending_q;
    if (clr_en) begin
      busy_d[rd] = 1'b0;
      pending_d  = pending_d - CNT_ONE;
    end
    if (set_en) begin
      busy_d[rsv_addr] = 1'b1;
      pending_d        = pending_d + CNT_ONE;
    end
  end

  // Scoreboard state, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_sb
// Description : Parametrised register file with asynchronous clear, optional
//               hardwired zero register, write-to-read bypass and a
//               destination scoreboard for RAW/WAW stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb
  import reg_file_sb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic     clk,
  input wire logic     rst,
  reg_file_sb_if.slave bus
);

  localparam int                DEPTH  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_IDX);

  logic signed [DATA_W-1:0] mem_q [DEPTH];
  logic                     eff_we;
  logic                     rs_is_zero, rt_is_zero;
  logic                     rs_bypass, rt_bypass;
  logic signed [DATA_W-1:0] data_one, data_two;

  // Writes to the zero register are dropped entirely.
  assign eff_we = bus.write_enable && !((ZERO_REG != 0) && (bus.rd == ZERO_A));

  assign rs_is_zero = (ZERO_REG != 0) && (bus.rs == ZERO_A);
  assign rt_is_zero = (ZERO_REG != 0) && (bus.rt == ZERO_A);
  assign rs_bypass  = (BYPASS != 0) && eff_we && (bus.rd == bus.rs);
  assign rt_bypass  = (BYPASS != 0) && eff_we && (bus.rd == bus.rt);

  for (genvar i = 0; i < DEPTH; i++) begin : g_regs
    logic signed [DATA_W-1:0] reg_d, reg_q;

    // Load writeback data when this entry is addressed.
    always_comb begin
      reg_d = reg_q;
      if (eff_we && (bus.rd == ADDR_W'(i))) begin
        reg_d = bus.data_in;
      end
    end

    // Storage flop, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign mem_q[i] = reg_q;
  end : g_regs

  // Read port one: array, then bypass, then zero/reset masking.
  always_comb begin
    data_one = mem_q[bus.rs];
    if (rs_bypass) begin
      data_one = bus.data_in;
    end
    if (rs_is_zero || rst) begin
      data_one = '0;
    end
  end

  // Read port two: array, then bypass, then zero/reset masking.
  always_comb begin
    data_two = mem_q[bus.rt];
    if (rt_bypass) begin
      data_two = bus.data_in;
    end
    if (rt_is_zero || rst) begin
      data_two = '0;
    end
  end

  assign bus.data_out_one = data_one;
  assign bus.data_out_two = data_two;

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .rs           (bus.rs),
    .rt           (bus.rt),
    .rd           (bus.rd),
    .write_enable (bus.write_enable),
    .eff_we       (eff_we),
    .rsv_valid    (bus.rsv_valid),
    .rsv_addr     (bus.rsv_addr),
    .rsv_ready    (bus.rsv_ready),
    .rs_busy      (bus.rs_busy),
    .rt_busy      (bus.rt_busy),
    .pending      (bus.pending)
  );

endmodule : reg_file_sb
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_sb
// Description : Directed self-checking bench for reg_file_sb with an
//               expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;
  import reg_file_sb_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  reg_file_sb #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model [32];

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL queue_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        miscompares++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic idle();
    bus.rs           = '0;
    bus.rt           = '0;
    bus.rd           = '0;
    bus.data_in      = '0;
    bus.write_enable = 1'b0;
    bus.rsv_valid    = 1'b0;
    bus.rsv_addr     = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset held: outputs forced quiet even with a bypassing write present.
    rst = 1'b1;
    idle();
    bus.write_enable = 1'b1;
    bus.rd           = 5'd5;
    bus.data_in      = 32'h1234_5678;
    bus.rs           = 5'd5;
    bus.rsv_addr     = 5'd9;
    repeat (2) @(negedge clk);
    expect_val("rst_data_one", 32'h0);
    expect_val("rst_rsv_ready", 32'h1);
    expect_val("rst_pending", 32'h0);
    #1;
    observe(bus.data_out_one);
    observe(32'(bus.rsv_ready));
    observe(32'(bus.pending));
    @(negedge clk);
    rst = 1'b0;
    idle();

    // Write r5 with same-cycle read (bypass), then read back from the array.
    bus.write_enable = 1'b1; bus.rd = 5'd5; bus.data_in = 32'h1234_5678;
    bus.rs = 5'd5; bus.rt = 5'd0;
    model[5] = 32'h1234_5678;
    expect_val("bypass_r5", 32'h1234_5678);
    expect_val("rt_r0", 32'h0);
    #1; observe(bus.data_out_one); observe(bus.data_out_two);
    next_cycle();
    idle(); bus.rs = 5'd5; bus.rt = 5'd0;
    expect_val("read_r5", model[5]);
    expect_val("read_r0", 32'h0);
    #1; observe(bus.data_out_one); observe(bus.data_out_two);

    // Write to the zero register is ignored.
    bus.write_enable = 1'b1; bus.rd = 5'd0; bus.data_in = 32'hDEAD_BEEF; bus.rs = 5'd0;
    expect_val("r0_bypass", 32'h0);
    #1; observe(bus.data_out_one);
    next_cycle();
    idle(); bus.rs = 5'd0;
    expect_val("r0_after_write", 32'h0);
    expect_val("r0_pending", 32'h0);
    #1; observe(bus.data_out_one); observe(32'(bus.pending));

    // Reserve r9, check busy, WAW stall, then release by writeback.
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    expect_val("r9_ready", 32'h1);
    #1; observe(32'(bus.rsv_ready));
    next_cycle();
    idle(); bus.rs = 5'd9; bus.rt = 5'd9; bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
    expect_val("r9_rs_busy", 32'h1);
    expect_val("r9_rt_busy", 32'h1);
    expect_val("r9_pending", 32'h1);
    expect_val("r9_waw_stall", 32'h0);
    #1;
    observe(32'(bus.rs_busy)); observe(32'(bus.rt_busy));
    observe(32'(bus.pending)); observe(32'(bus.rsv_ready));
    next_cycle();
    idle(); bus.rs = 5'd9;
    bus.write_enable = 1'b1; bus.rd = 5'd9; bus.data_in = 32'h0000_0099;
    model[9] = 32'h0000_0099;
    expect_val("r9_pending_hold", 32'h1);
    expect_val("r9_wb_not_busy", 32'h0);
    expect_val("r9_wb_data", 32'h0000_0099);
    #1;
    observe(32'(bus.pending)); observe(32'(bus.rs_busy)); observe(bus.data_out_one);
    next_cycle();
    idle(); bus.rs = 5'd9;
    expect_val("r9_released", 32'h0);
    expect_val("r9_pending_zero", 32'h0);
    #1; observe(32'(bus.rs_busy)); observe(32'(bus.pending));

    // Reserved r7 written with same-cycle read: forwarded and not busy.
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
    next_cycle();
    idle(); bus.rs = 5'd7;
    bus.write_enable = 1'b1; bus.rd = 5'd7; bus.data_in = 32'h0000_CAFE;
    model[7] = 32'h0000_CAFE;
    expect_val("r7_bypass", 32'h0000_CAFE);
    expect_val("r7_not_busy", 32'h0);
    #1; observe(bus.data_out_one); observe(32'(bus.rs_busy));
    next_cycle();
    idle();
    expect_val("r7_pending_zero", 32'h0);
    #1; observe(32'(bus.pending));

    // r3 reserved, then reserve+write r3 in the same cycle: set wins.
    bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
    next_cycle();
    idle(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd3;
    bus.write_enable = 1'b1; bus.rd = 5'd3; bus.data_in = 32'h0000_3333;
    model[3] = 32'h0000_3333;
    expect_val("r3_ready_on_wb", 32'h1);
    #1; observe(32'(bus.rsv_ready));
    next_cycle();
    idle(); bus.rs = 5'd3;
    expect_val("r3_still_busy", 32'h1);
    expect_val("r3_pending", 32'h1);
    expect_val("r3_data", model[3]);
    #1; observe(32'(bus.rs_busy)); observe(32'(bus.pending)); observe(bus.data_out_one);
    bus.write_enable = 1'b1; bus.rd = 5'd3; bus.data_in = 32'h0000_3334;
    model[3] = 32'h0000_3334;
    next_cycle();

    // Reserving r0 is always ready and never counted.
    idle(); bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
    expect_val("r0_rsv_ready", 32'h1);
    #1; observe(32'(bus.rsv_ready));
    next_cycle();
    idle();
    expect_val("r0_rsv_pending", 32'h0);
    #1; observe(32'(bus.pending));

    // Distinct patterns into r1..r8, read back crossed on both ports.
    for (int i = 1; i <= 8; i++) begin
      idle();
      bus.write_enable = 1'b1;
      bus.rd           = 5'(i);
      bus.data_in      = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      model[i]         = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
      next_cycle();
    end
    for (int i = 1; i <= 8; i++) begin
      idle();
      bus.rs = 5'(i);
      bus.rt = 5'(9 - i);
      expect_val("pattern_one", model[i]);
      expect_val("pattern_two", model[9 - i]);
      #1; observe(bus.data_out_one); observe(bus.data_out_two);
      next_cycle();
    end

    // Fill every non-zero register's reservation.
    for (int i = 1; i < 32; i++) begin
      idle();
      bus.rsv_valid = 1'b1;
      bus.rsv_addr  = 5'(i);
      expect_val("fill_ready", 32'h1);
      #1; observe(32'(bus.rsv_ready));
      next_cycle();
    end
    idle(); bus.rs = 5'd17; bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd17;
    expect_val("full_pending", 32'd31);
    expect_val("full_busy", 32'h1);
    expect_val("full_stall", 32'h0);
    #1; observe(32'(bus.pending)); observe(32'(bus.rs_busy)); observe(32'(bus.rsv_ready));
    idle();

    // Asynchronous reset asserted mid-cycle clears everything at once.
    @(posedge clk);
    #2;
    bus.rs = 5'd17; bus.rt = 5'd5; bus.rsv_addr = 5'd17;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    expect_val("arst_pending", 32'h0);
    expect_val("arst_busy", 32'h0);
    expect_val("arst_r5", 32'h0);
    expect_val("arst_ready", 32'h1);
    #1;
    observe(32'(bus.pending)); observe(32'(bus.rs_busy));
    observe(bus.data_out_two); observe(32'(bus.rsv_ready));
    @(negedge clk);
    rst = 1'b0;

    // Writes resume after release; earlier contents stay cleared.
    idle();
    bus.write_enable = 1'b1; bus.rd = 5'd12; bus.data_in = 32'h0000_ABCD;
    model[12] = 32'h0000_ABCD;
    next_cycle();
    idle(); bus.rs = 5'd12; bus.rt = 5'd5;
    expect_val("post_rst_r12", model[12]);
    expect_val("post_rst_r5", model[5]);
    expect_val("post_rst_pending", 32'h0);
    #1; observe(bus.data_out_one); observe(bus.data_out_two); observe(32'(bus.pending));
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_reg_file_sb
`default_nettype wire
